// File: rtl/inv_sbox_serial_if.sv
// inv_sbox_serial_if: handshake bundle for the serial inverse-substitution unit.
//   NIB       - nibbles per word (word width is 4*NIB)
//   IN_VALID  - source offers a word          (master -> slave)
//   IN_READY  - unit can accept a word        (slave  -> master)
//   IN_DATA   - substituted input word        (master -> slave)
//   OUT_VALID - result word available         (slave  -> master)
//   OUT_READY - consumer accepts the result   (master -> slave)
//   OUT_DATA  - inverse-substituted word      (slave  -> master)
//   OUT_ERR   - some nibble had no preimage   (slave  -> master)
//   OUT_AMB   - some nibble had two preimages (slave  -> master)
interface inv_sbox_serial_if #(
  parameter int unsigned NIB = 4
);
  logic               IN_VALID;
  logic               IN_READY;
  logic [4*NIB-1:0]   IN_DATA;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [4*NIB-1:0]   OUT_DATA;
  logic               OUT_ERR;
  logic               OUT_AMB;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_ERR, OUT_AMB
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_ERR, OUT_AMB
  );
endinterface

// File: rtl/inv_sbox_serial.sv
// inv_sbox_serial: serial inverse-substitution unit.
// Accepts a word of NIB nibbles, replaces each nibble (LSB nibble first, one
// per clock) with its preimage under the 4-bit substitution S, and returns the
// result with sticky error (no preimage) and ambiguity (two preimages) flags.
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset
//   bus   - slave side of inv_sbox_serial_if (input and output handshakes)
module inv_sbox_serial #(
  parameter int unsigned NIB = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  inv_sbox_serial_if.slave  bus
);

  localparam int unsigned    W    = 4 * NIB;
  localparam int unsigned    CW   = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0]  LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  sreg;       // captured input word
  logic [W-1:0]  acc;        // result under construction
  logic [W-1:0]  acc_nx;
  logic [CW-1:0] cnt;
  logic [CW+1:0] base;       // bit offset of nibble cnt (4*cnt)
  logic [3:0]    nib;
  logic [3:0]    inv;
  logic          nerr;
  logic          namb;
  logic          err_acc;
  logic          amb_acc;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          out_err_q;
  logic          out_amb_q;

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_ERR   = out_err_q;
  assign bus.OUT_AMB   = out_amb_q;

  // Single S^-1 lookup shared by all nibble positions.
  // Input 7 has preimages {0,4}: the lower one is returned and flagged.
  // Input B has no preimage: 0 is returned and flagged as an error.
  always_comb begin
    base = {cnt, 2'b00};
    nib  = sreg[base +: 4];
    case (nib)
      4'h0:    inv = 4'hD;
      4'h1:    inv = 4'h9;
      4'h2:    inv = 4'h5;
      4'h3:    inv = 4'h1;
      4'h4:    inv = 4'hA;
      4'h5:    inv = 4'h6;
      4'h6:    inv = 4'h2;
      4'h7:    inv = 4'h0;
      4'h8:    inv = 4'h8;
      4'h9:    inv = 4'hC;
      4'hA:    inv = 4'hB;
      4'hB:    inv = 4'h0;
      4'hC:    inv = 4'h7;
      4'hD:    inv = 4'h3;
      4'hE:    inv = 4'hF;
      4'hF:    inv = 4'hE;
      default: inv = 4'h0;
    endcase
    nerr   = (nib == 4'hB);
    namb   = (nib == 4'h7);
    acc_nx = acc;
    acc_nx[base +: 4] = inv;
  end

  // The result is built in acc and copied to the output registers only on the
  // final RUN edge, so OUT_DATA/OUT_ERR/OUT_AMB keep the previous word's values
  // through IDLE and RUN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      sreg        <= '0;
      acc         <= '0;
      cnt         <= '0;
      err_acc     <= 1'b0;
      amb_acc     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_amb_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.IN_VALID && in_ready_q) begin
            sreg       <= bus.IN_DATA;
            acc        <= '0;
            err_acc    <= 1'b0;
            amb_acc    <= 1'b0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc     <= acc_nx;
          err_acc <= err_acc | nerr;
          amb_acc <= amb_acc | namb;
          if (cnt == LAST) begin
            out_data_q  <= acc_nx;
            out_err_q   <= err_acc | nerr;
            out_amb_q   <= amb_acc | namb;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sbox_serial.sv
// tb_inv_sbox_serial: self-checking bench for inv_sbox_serial.
// Drives a NIB=4 instance through directed vectors, multi-cycle corner cases
// and random words, and a NIB=1 instance through all 16 nibble values.
module tb_inv_sbox_serial;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  inv_sbox_serial_if #(.NIB(4)) b4 ();
  inv_sbox_serial_if #(.NIB(1)) b1 ();

  inv_sbox_serial #(.NIB(4)) dut4 (.CLK(clk), .RST_N(rst_n), .bus(b4));
  inv_sbox_serial #(.NIB(1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Forward substitution S; the reference inverts it by search.
  localparam logic [3:0] FWD [16] = '{4'h7, 4'h3, 4'h6, 4'hD, 4'h7, 4'h2, 4'h5, 4'hC,
                                      4'h8, 4'h1, 4'h4, 4'hA, 4'h9, 4'h0, 4'hF, 4'hE};

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    bit          err;
    bit          amb;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inv_ref(input logic [3:0] v, output logic [3:0] r, output bit e, output bit a);
    int unsigned hits;
    hits = 0;
    r = '0;
    for (int x = 15; x >= 0; x--) begin
      if (FWD[x] == v) begin
        r = 4'(x);
        hits++;
      end
    end
    e = (hits == 0);
    a = (hits == 2);
  endtask

  task automatic word_ref(input logic [15:0] d, output logic [15:0] r, output bit e, output bit a);
    logic [3:0] nr;
    bit ne, na;
    r = '0; e = 1'b0; a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inv_ref(d[4*i +: 4], nr, ne, na);
      r[4*i +: 4] = nr;
      e |= ne;
      a |= na;
    end
  endtask

  // Offer a word to the NIB=4 instance, wait for acceptance, then count cycles
  // until OUT_VALID. IN_DATA is scrambled after acceptance.
  task automatic send4(input logic [15:0] d, output int lat);
    int n;
    b4.IN_DATA  = d;
    b4.IN_VALID = 1'b1;
    n = 0;
    while (!b4.IN_READY && n < 50) begin tick(); n++; end
    chk("in_ready_wait", b4.IN_READY, 1);
    tick();
    b4.IN_VALID = 1'b0;
    b4.IN_DATA  = 16'($urandom);
    lat = 0;
    while (!b4.OUT_VALID && lat < 50) begin tick(); lat++; end
  endtask

  task automatic hs4();
    b4.OUT_READY = 1'b1;
    tick();
    b4.OUT_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[6];
    int          lat;
    int          seen;
    int          prev_t;
    int          acc_t;
    int          n;
    logic [15:0] d, ed;
    logic [3:0]  er;
    bit          ee, ea, early;

    vt[0] = '{16'h0123, 16'hD951, 1'b0, 1'b0};
    vt[1] = '{16'hFEDC, 16'hEF37, 1'b0, 1'b0};
    vt[2] = '{16'h7B8A, 16'h008B, 1'b1, 1'b1};
    vt[3] = '{16'h4567, 16'hA620, 1'b0, 1'b1};
    vt[4] = '{16'h0000, 16'hDDDD, 1'b0, 1'b0};
    vt[5] = '{16'hBBBB, 16'h0000, 1'b1, 1'b0};

    rst_n        = 1'b0;
    b4.IN_VALID  = 1'b1;
    b4.IN_DATA   = 16'h0123;
    b4.OUT_READY = 1'b0;
    b1.IN_VALID  = 1'b0;
    b1.IN_DATA   = '0;
    b1.OUT_READY = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready",  b4.IN_READY, 1);
    chk("rst_out_valid", b4.OUT_VALID, 0);
    chk("rst_out_data",  b4.OUT_DATA, 0);
    chk("rst_out_err",   b4.OUT_ERR, 0);
    chk("rst_out_amb",   b4.OUT_AMB, 0);
    chk("rst1_out_valid", b1.OUT_VALID, 0);

    // First word accepted on the first edge after release, NIB cycles latency
    #10 rst_n = 1'b1;
    tick();
    b4.IN_VALID = 1'b0;
    chk("first_accept", b4.IN_READY, 0);
    lat = 0;
    while (!b4.OUT_VALID && lat < 50) begin tick(); lat++; end
    chk("first_lat",  lat, 4);
    chk("first_data", b4.OUT_DATA, 16'hD951);
    chk("first_err",  b4.OUT_ERR, 0);
    chk("first_amb",  b4.OUT_AMB, 0);
    hs4();
    chk("first_hs_valid", b4.OUT_VALID, 0);
    chk("first_hs_ready", b4.IN_READY, 1);

    // Output stall: DONE holds the word while OUT_READY is low
    send4(16'hFEDC, lat);
    chk("stall_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", b4.OUT_VALID, 1);
      chk("stall_data",  b4.OUT_DATA, 16'hEF37);
      chk("stall_ready", b4.IN_READY, 0);
      tick();
    end
    hs4();
    chk("stall_hs_valid", b4.OUT_VALID, 0);
    chk("stall_hs_ready", b4.IN_READY, 1);

    // Input handshake ignored during RUN; the word is output exactly once
    b4.IN_DATA  = 16'h0123;
    b4.IN_VALID = 1'b1;
    tick();
    b4.IN_DATA = 16'h7B8A;
    lat = 0;
    while (!b4.OUT_VALID && lat < 50) begin
      chk("run_in_ready", b4.IN_READY, 0);
      tick();
      lat++;
      if (lat == 2) b4.IN_VALID = 1'b0;
    end
    chk("ign_lat",  lat, 4);
    chk("ign_data", b4.OUT_DATA, 16'hD951);
    hs4();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (b4.OUT_VALID) seen++;
      tick();
    end
    chk("ign_extra_outputs", seen, 0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      send4(vt[i].din, lat);
      chk("vec_lat",  lat, 4);
      chk("vec_data", b4.OUT_DATA, vt[i].dout);
      chk("vec_err",  b4.OUT_ERR, vt[i].err);
      chk("vec_amb",  b4.OUT_AMB, vt[i].amb);
      repeat (i) tick();
      hs4();
      chk("vec_hs_valid", b4.OUT_VALID, 0);
      chk("vec_hs_ready", b4.IN_READY, 1);
    end

    // Flags are per word: 7B8A then 4567
    send4(16'h7B8A, lat);
    chk("flag1_err", b4.OUT_ERR, 1);
    chk("flag1_amb", b4.OUT_AMB, 1);
    hs4();
    send4(16'h4567, lat);
    chk("flag2_err",  b4.OUT_ERR, 0);
    chk("flag2_amb",  b4.OUT_AMB, 1);
    chk("flag2_data", b4.OUT_DATA, 16'hA620);
    hs4();

    // Asynchronous reset in the second RUN cycle discards the word
    b4.IN_DATA  = 16'h0123;
    b4.IN_VALID = 1'b1;
    tick();
    b4.IN_VALID = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", b4.OUT_VALID, 0);
    chk("arst_in_ready",  b4.IN_READY, 1);
    chk("arst_out_data",  b4.OUT_DATA, 0);
    chk("arst_out_err",   b4.OUT_ERR, 0);
    chk("arst_out_amb",   b4.OUT_AMB, 0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b4.OUT_VALID) seen++;
    end
    chk("arst_no_output", seen, 0);
    send4(16'hFFFF, lat);
    chk("post_rst_lat",  lat, 4);
    chk("post_rst_data", b4.OUT_DATA, 16'hEEEE);
    hs4();

    // Random words against the reference model, random stalls, early OUT_READY
    for (int k = 0; k < 40; k++) begin
      d = 16'($urandom);
      early = 1'($urandom_range(0, 1));
      b4.OUT_READY = early;
      send4(d, lat);
      word_ref(d, ed, ee, ea);
      chk("rnd_lat",  lat, 4);
      chk("rnd_data", b4.OUT_DATA, ed);
      chk("rnd_err",  b4.OUT_ERR, ee);
      chk("rnd_amb",  b4.OUT_AMB, ea);
      if (!early) repeat ($urandom_range(0, 3)) tick();
      hs4();
      chk("rnd_hs_valid", b4.OUT_VALID, 0);
    end

    // NIB=1: all 16 values, latency 1, accept-to-accept spacing 3
    b1.OUT_READY = 1'b1;
    b1.IN_VALID  = 1'b1;
    prev_t = 0;
    for (int v = 0; v < 16; v++) begin
      b1.IN_DATA = 4'(v);
      n = 0;
      while (!b1.IN_READY && n < 20) begin tick(); n++; end
      chk("n1_ready_wait", b1.IN_READY, 1);
      tick();
      acc_t = cyc;
      if (v > 0) chk("n1_spacing", acc_t - prev_t, 3);
      prev_t = acc_t;
      lat = 0;
      while (!b1.OUT_VALID && lat < 20) begin tick(); lat++; end
      inv_ref(4'(v), er, ee, ea);
      chk("n1_lat",  lat, 1);
      chk("n1_data", b1.OUT_DATA, er);
      chk("n1_err",  b1.OUT_ERR, ee);
      chk("n1_amb",  b1.OUT_AMB, ea);
    end
    b1.IN_VALID = 1'b0;
    tick();
    tick();
    chk("n1_final_valid", b1.OUT_VALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
